// File: rtl/timer_dev_pkg.sv
// Shared constants and types for the peripheral-bus countdown timer.
package timer_dev_pkg;

  // Default device window: the timer answers for addresses 0x7F00..0x7F0F.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

  // Word offsets inside the device window, taken from addr[3:2].
  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  // Bit positions of the CTRL register fields.
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // Counting modes; the encodings 1x fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Countdown controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Only the exact RELOAD encoding reloads; everything else is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer responding on the CPU peripheral bus.
// Holds CTRL/PRESET/COUNT registers, a four-state countdown controller and
// the interrupt request that feeds one bit of the CPU hardware interrupt vector.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  logic         sel;
  logic [1:0]   offset;
  logic         ctrl_wr;
  logic         preset_wr;
  logic         en_eff;

  logic         ctrl_en;
  logic [1:0]   ctrl_mode;
  logic         ctrl_im;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         flag;

  timer_state_e state;
  timer_state_e state_next;
  logic [31:0]  count_next;
  logic         fsm_clear_en;
  logic         fsm_set_flag;

  // Byte-lane bits and the unused upper CTRL write bits are deliberately ignored.
  logic         unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:4]};

  // The device owns a 16-byte window; the word offset picks the register.
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:2];
  assign ctrl_wr   = we && sel && (offset == CTRL_OFF);
  assign preset_wr = we && sel && (offset == PRESET_OFF);

  // A CTRL write clearing EN freezes COUNT at the very edge it lands on.
  assign en_eff = ctrl_wr ? wdata[CTRL_EN_BIT] : ctrl_en;

  // Next-state and next-count logic of the countdown controller.
  always_comb begin
    state_next   = state;
    count_next   = count;
    fsm_clear_en = 1'b0;
    fsm_set_flag = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = (preset == 32'd0) ? ST_INT : ST_CNT;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_next = ST_IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          count_next = 32'd0;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_mode)) begin
          state_next = ST_LOAD;
        end else begin
          fsm_set_flag = 1'b1;
          fsm_clear_en = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller state and the live count value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // CTRL register; a CPU write takes priority over the one-shot EN clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en   <= wdata[CTRL_EN_BIT];
      ctrl_mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      ctrl_im   <= wdata[CTRL_IM_BIT];
    end else if (fsm_clear_en) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESET register; only consulted when the controller passes through LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      preset <= wdata;
    end
  end

  // Sticky one-shot expiry flag; any CTRL/PRESET write clears it and wins over a set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag <= 1'b0;
    end else if (ctrl_wr || preset_wr) begin
      flag <= 1'b0;
    end else if (fsm_set_flag) begin
      flag <= 1'b1;
    end
  end

  // Read mux; unselected addresses and the spare offset read as zero.
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (offset)
        CTRL_OFF:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        PRESET_OFF: rdata = preset;
        COUNT_OFF:  rdata = count;
        default:    rdata = 32'd0;
      endcase
    end
  end

  // Level interrupt in one-shot mode, single-cycle pulse in auto-reload mode.
  assign irq = ctrl_im && (flag || ((state == ST_INT) && is_reload(ctrl_mode)));

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: random presets and bus traffic, expected
// values computed from the timer's cycle-level timing rules.
module tb_timer_dev;

  localparam logic [31:0] BASE       = 32'h0000_7F00;
  localparam logic [1:0]  CTRL_OFF   = 2'd0;
  localparam logic [1:0]  PRESET_OFF = 2'd1;
  localparam logic [1:0]  COUNT_OFF  = 2'd2;
  localparam logic [1:0]  SPARE_OFF  = 2'd3;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_dev dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    addr  = BASE | {28'd0, off, 2'b00};
    wdata = data;
    we    = 1'b1;
    step();
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    addr = BASE | {28'd0, off, 2'b00};
    #1;
    data = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    we  = 1'b0;
    addr = BASE;
    wdata = 32'd0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      addr  = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      wdata = $urandom;
      we    = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (rdata !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_rdata: got %h required %h", rdata, 32'd0);
      end
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_irq: got %b required 0", irq);
      end
      step();
    end
    we = 1'b0;
    rst = 1'b1;
    step();
    for (int o = 0; o < 3; o++) begin
      bus_read(2'(o), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("[TB] FAIL post_reset_reg%0d: got %h required %h", o, rd, 32'd0);
      end
    end
  endtask

  task automatic test_oneshot(input int n);
    logic [31:0] rd;
    int exp_cnt;
    logic exp_irq;
    bus_write(PRESET_OFF, 32'(n));
    bus_write(CTRL_OFF, 32'h9);
    for (int t = 1; t <= n + 6; t++) begin
      step();
      if (t >= 2) begin
        exp_cnt = (t - 2 >= n) ? 0 : n - (t - 2);
        bus_read(COUNT_OFF, rd);
        checks++;
        if (rd !== 32'(exp_cnt)) begin
          errors++;
          $display("[TB] FAIL oneshot_count n=%0d t=%0d: got %0d required %0d", n, t, rd, exp_cnt);
        end
      end
      exp_irq = (t >= n + 3);
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("[TB] FAIL oneshot_irq n=%0d t=%0d: got %b required %b", n, t, irq, exp_irq);
      end
    end
    bus_read(CTRL_OFF, rd);
    checks++;
    if (rd !== 32'h8) begin
      errors++;
      $display("[TB] FAIL oneshot_ctrl_after: got %h required %h", rd, 32'h8);
    end
    bus_write(CTRL_OFF, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_irq_clear: got %b required 0", irq);
    end
  endtask

  task automatic test_reload(input int n, input logic im);
    logic [31:0] rd;
    int p;
    int per;
    int exp_cnt;
    logic exp_irq;
    per = n + 2;
    bus_write(PRESET_OFF, 32'(n));
    bus_write(CTRL_OFF, im ? 32'hB : 32'h3);
    for (int t = 1; t <= 2 + 3 * per + 1; t++) begin
      step();
      exp_irq = 1'b0;
      if (t >= 2) begin
        p = (t - 2) % per;
        exp_cnt = (p <= n) ? n - p : 0;
        exp_irq = im && (p == n);
        bus_read(COUNT_OFF, rd);
        checks++;
        if (rd !== 32'(exp_cnt)) begin
          errors++;
          $display("[TB] FAIL reload_count n=%0d im=%b t=%0d: got %0d required %0d", n, im, t, rd, exp_cnt);
        end
      end
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("[TB] FAIL reload_irq n=%0d im=%b t=%0d: got %b required %b", n, im, t, irq, exp_irq);
      end
    end
    bus_write(CTRL_OFF, 32'h0);
    repeat (4) step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reload_stop_irq: got %b required 0", irq);
    end
  endtask

  task automatic test_pause_and_zero();
    logic [31:0] rd;
    int n;
    bit found;
    n = 12 + int'($urandom_range(0, 8));
    bus_write(PRESET_OFF, 32'(n));
    bus_write(CTRL_OFF, 32'h9);
    step();
    step();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      bus_read(COUNT_OFF, rd);
      if (rd == 32'd7) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL pause_reach7: got %0d required 7 within 40 cycles", rd);
    end
    bus_write(CTRL_OFF, 32'h8);
    for (int i = 0; i < 4; i++) begin
      bus_read(COUNT_OFF, rd);
      checks++;
      if (rd !== 32'd7) begin
        errors++;
        $display("[TB] FAIL pause_frozen i=%0d: got %0d required 7", i, rd);
      end
      step();
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_irq: got %b required 0", irq);
    end
    bus_write(PRESET_OFF, 32'd0);
    bus_write(CTRL_OFF, 32'h9);
    for (int t = 1; t <= 5; t++) begin
      step();
      checks++;
      if (irq !== (t >= 3)) begin
        errors++;
        $display("[TB] FAIL zero_preset_irq t=%0d: got %b required %b", t, irq, (t >= 3));
      end
      if (t >= 2) begin
        bus_read(COUNT_OFF, rd);
        checks++;
        if (rd !== 32'd0) begin
          errors++;
          $display("[TB] FAIL zero_preset_count t=%0d: got %0d required 0", t, rd);
        end
      end
    end
    bus_write(CTRL_OFF, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_preset_clear: got %b required 0", irq);
    end
  endtask

  task automatic test_mode_change(input int n);
    logic [31:0] rd;
    int exp_cnt;
    bus_write(PRESET_OFF, 32'(n));
    bus_write(CTRL_OFF, 32'hB);
    step();
    step();
    bus_write(CTRL_OFF, 32'h9);
    for (int t = 3; t <= n + 5; t++) begin
      if (t > 3) step();
      exp_cnt = (t - 2 >= n) ? 0 : n - (t - 2);
      bus_read(COUNT_OFF, rd);
      checks++;
      if (rd !== 32'(exp_cnt)) begin
        errors++;
        $display("[TB] FAIL mode_change_count n=%0d t=%0d: got %0d required %0d", n, t, rd, exp_cnt);
      end
      checks++;
      if (irq !== (t >= n + 3)) begin
        errors++;
        $display("[TB] FAIL mode_change_irq n=%0d t=%0d: got %b required %b", n, t, irq, (t >= n + 3));
      end
    end
    bus_write(CTRL_OFF, 32'h8);
  endtask

  task automatic test_collision(input int n, input logic [31:0] data);
    logic [31:0] rd;
    bus_write(PRESET_OFF, 32'(n));
    bus_write(CTRL_OFF, 32'h9);
    for (int t = 1; t <= n + 2; t++) step();
    bus_write(CTRL_OFF, data);
    bus_read(CTRL_OFF, rd);
    checks++;
    if (rd !== {28'd0, data[3:0]}) begin
      errors++;
      $display("[TB] FAIL collision_ctrl: got %h required %h", rd, {28'd0, data[3:0]});
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_flag: got irq %b required 0", irq);
    end
    if (data[0]) begin
      for (int u = 1; u <= n + 4; u++) begin
        step();
        checks++;
        if (irq !== (u >= n + 3)) begin
          errors++;
          $display("[TB] FAIL collision_restart_irq u=%0d: got %b required %b", u, irq, (u >= n + 3));
        end
        if (u == 2) begin
          bus_read(COUNT_OFF, rd);
          checks++;
          if (rd !== 32'(n)) begin
            errors++;
            $display("[TB] FAIL collision_restart_count: got %0d required %0d", rd, n);
          end
        end
      end
    end
    bus_write(CTRL_OFF, 32'h0);
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    logic [31:0] v;
    logic [31:0] c;
    logic [31:0] pr;
    v = $urandom;
    bus_write(PRESET_OFF, v);
    bus_read(PRESET_OFF, rd);
    checks++;
    if (rd !== v) begin
      errors++;
      $display("[TB] FAIL decode_preset: got %h required %h", rd, v);
    end
    v = $urandom & 32'hFFFF_FFFE;
    bus_write(CTRL_OFF, v);
    bus_read(CTRL_OFF, rd);
    checks++;
    if (rd !== (v & 32'hE)) begin
      errors++;
      $display("[TB] FAIL decode_ctrl: got %h required %h", rd, v & 32'hE);
    end
    bus_read(COUNT_OFF, c);
    bus_write(COUNT_OFF, ~c);
    bus_read(COUNT_OFF, rd);
    checks++;
    if (rd !== c) begin
      errors++;
      $display("[TB] FAIL decode_count_ro: got %h required %h", rd, c);
    end
    bus_write(SPARE_OFF, $urandom | 32'h1);
    bus_read(SPARE_OFF, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("[TB] FAIL decode_spare: got %h required 0", rd);
    end
    bus_read(PRESET_OFF, pr);
    addr  = 32'h0000_7F10 | {28'd0, 2'($urandom_range(0, 1)), 2'b00};
    wdata = $urandom | 32'h9;
    we    = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL decode_outside_rdata: got %h required 0", rdata);
    end
    step();
    we = 1'b0;
    bus_read(CTRL_OFF, rd);
    checks++;
    if (rd !== (v & 32'hE)) begin
      errors++;
      $display("[TB] FAIL decode_outside_ctrl: got %h required %h", rd, v & 32'hE);
    end
    bus_read(PRESET_OFF, rd);
    checks++;
    if (rd !== pr) begin
      errors++;
      $display("[TB] FAIL decode_outside_preset: got %h required %h", rd, pr);
    end
    bus_write(CTRL_OFF, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(PRESET_OFF, 32'd2);
    bus_write(CTRL_OFF, 32'h9);
    repeat (5) step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre_irq: got %b required 1", irq);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_irq_drop: got %b required 0", irq);
    end
    for (int o = 0; o < 3; o++) begin
      bus_read(2'(o), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("[TB] FAIL async_reg%0d: got %h required 0", o, rd);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_oneshot(5);
    for (int i = 0; i < 3; i++) test_oneshot(int'($urandom_range(1, 20)));
    test_reload(3, 1'b1);
    test_reload(int'($urandom_range(1, 6)), 1'b1);
    test_reload(int'($urandom_range(1, 6)), 1'b0);
    test_pause_and_zero();
    test_mode_change(int'($urandom_range(4, 10)));
    test_collision(int'($urandom_range(1, 8)), 32'h9);
    test_collision(int'($urandom_range(1, 8)), ($urandom & 32'hFFFF_FFF6) | 32'h8);
    test_decode();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
